snd_i2s_tx: RTL

I2S serializer for the sound path, clocked by the sound master clock (11.2896 MHz = 256 × 44.1 kHz). Accepts one stereo sample pair per frame from the mixer through a valid/ready handshake and one-entry holding buffer. Derives BCLK (64 × fs) and LRCK (fs) by dividing the master clock, and drives serial data to the external DAC. Sits directly downstream of the MCLK generator; SND_MCLK is also routed unchanged to the DAC MCLK pin outside this block.

---
 rtl/snd_i2s_tx_if.sv | 24 ++
 rtl/snd_i2s_tx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/snd_i2s_tx_if.sv
// Sample handshake between the mixer (master) and the I2S serializer (slave).
// One stereo pair is offered per transfer under a valid/ready handshake.
interface snd_i2s_tx_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/snd_i2s_tx.sv
// I2S serializer: MCLK/4 bit clock, MCLK/256 word select, one-entry sample buffer.
// Optional macro SND_UNDERRUN_ZERO_EN: underrun frames play silence instead of repeating the last pair.
module snd_i2s_tx #(
  parameter int SAMPLE_W = 16
) (
  input  logic         snd_mclk_i,
  input  logic         rst_i,
  snd_i2s_tx_if.slave  smp_if,
  output logic         frame_stb_o,
  output logic         i2s_bclk_o,
  output logic         i2s_lrck_o,
  output logic         i2s_sdata_o,
  output logic [7:0]   underrun_cnt_o
);

  localparam logic [5:0] SW = 6'(SAMPLE_W);

  logic [7:0]          cnt_q, cnt_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [SAMPLE_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic [7:0]          und_q, und_d;
  logic                stb_q, stb_d;
  logic                sdata_q, sdata_d;
  logic                load, xfer, ready, in_word;
  logic [4:0]          slot_n;

  // Ready is the registered empty flag, forced low while reset is held.
  assign ready               = ~full_q & ~rst_i;
  assign smp_if.sample_ready = ready;

  assign frame_stb_o    = stb_q;
  assign i2s_bclk_o     = cnt_q[1];
  assign i2s_lrck_o     = cnt_q[7];
  assign i2s_sdata_o    = sdata_q;
  assign underrun_cnt_o = und_q;

  always_comb begin
    cnt_d    = cnt_q + 8'd1;
    load     = (cnt_q == 8'hFF);
    xfer     = smp_if.sample_valid & ready;
    full_d   = full_q;
    buf_l_d  = buf_l_q;
    buf_r_d  = buf_r_q;
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    last_l_d = last_l_q;
    last_r_d = last_r_q;
    und_d    = und_q;
    sdata_d  = sdata_q;
    stb_d    = (cnt_d == 8'hFF);
    slot_n   = cnt_d[6:2];
    in_word  = (slot_n != 5'd0) && ({1'b0, slot_n} <= SW);

    // Data is launched one MCLK ahead of the BCLK falling edge so it is registered on it.
    if (cnt_q[1:0] == 2'd3) begin
      sdata_d = 1'b0;
      if (in_word) begin
        if (cnt_d[7]) begin
          sdata_d = sh_r_q[SAMPLE_W-1];
          sh_r_d  = {sh_r_q[SAMPLE_W-2:0], 1'b0};
        end else begin
          sdata_d = sh_l_q[SAMPLE_W-1];
          sh_l_d  = {sh_l_q[SAMPLE_W-2:0], 1'b0};
        end
      end
    end

    if (load) begin
      full_d = 1'b0;
      if (full_q) begin
        sh_l_d   = buf_l_q;
        sh_r_d   = buf_r_q;
        last_l_d = buf_l_q;
        last_r_d = buf_r_q;
      end else begin
        und_d = (und_q == 8'hFF) ? und_q : und_q + 8'd1;
`ifdef SND_UNDERRUN_ZERO_EN
        sh_l_d = '0;
        sh_r_d = '0;
`else
        sh_l_d = last_l_q;
        sh_r_d = last_r_q;
`endif
      end
    end

    // A transfer coinciding with an empty-buffer load lands in the buffer for the next frame.
    if (xfer) begin
      full_d  = 1'b1;
      buf_l_d = smp_if.sample_l;
      buf_r_d = smp_if.sample_r;
    end
  end

  always_ff @(posedge snd_mclk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      full_q   <= 1'b0;
      buf_l_q  <= '0;
      buf_r_q  <= '0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
      und_q    <= '0;
      stb_q    <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      buf_l_q  <= buf_l_d;
      buf_r_q  <= buf_r_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
      und_q    <= und_d;
      stb_q    <= stb_d;
      sdata_q  <= sdata_d;
    end
  end

endmodule
